// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   SPI initiator for the SoC's SPI peripheral link. It pops one word from a
//   show-ahead TX FIFO and shifts it out MSB-first on o_MOSI while it captures
//   i_MISO. It then pushes the received word into the RX FIFO. Each word gets
//   its own chip-select frame. All four SPI modes are supported, with word
//   lengths of 1..DW bits and a programmable SCLK half-period.
//
//   Frame sequence (D = CLKDIV+1, N = LEN+1):
//     IDLE (>=1) -> LEAD (D) -> XFER (2N*D) -> TRAIL (D) -> GAP (D) -> IDLE
//   The frame period is 1 + D*(2N+3) cycles. o_CSn is low for D*(2N+2) cycles.
//
// Ports
//   sclk_sample  block clock, all logic on its rising edge
//   rstn         asynchronous active-low reset
//   i_en         frames start only while high
//   i_tx_empty   TX FIFO empty
//   o_rd_TX      TX FIFO pop (1-cycle pulse); i_dataTX is the FIFO head
//   i_dataTX     word to send
//   i_rx_full    RX FIFO full; no frame starts while set
//   o_wr_RX      RX FIFO push (1-cycle pulse, first GAP cycle)
//   o_dataRX     received word, right-aligned, upper bits zero
//   CPolPha      [1] CPOL (SCLK idle level), [0] CPHA
//   LEN          bits per word minus one
//   CLKDIV       SCLK half-period minus one, in sclk_sample cycles
//   o_busy       high in every state except IDLE
//   o_SCLK       SPI clock
//   o_MOSI       SPI data out
//   i_MISO       SPI data in
//   o_CSn        chip select, active low
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int DW   = 16,
  parameter int DIVW = 8,
  localparam int LW  = $clog2(DW)
) (
  input  logic            sclk_sample,
  input  logic            rstn,
  input  logic            i_en,
  input  logic            i_tx_empty,
  output logic            o_rd_TX,
  input  logic [DW-1:0]   i_dataTX,
  input  logic            i_rx_full,
  output logic            o_wr_RX,
  output logic [DW-1:0]   o_dataRX,
  input  logic [1:0]      CPolPha,
  input  logic [LW-1:0]   LEN,
  input  logic [DIVW-1:0] CLKDIV,
  output logic            o_busy,
  output logic            o_SCLK,
  output logic            o_MOSI,
  input  logic            i_MISO,
  output logic            o_CSn
);

  // The edge counter must reach 2*DW without wrapping.
  localparam int EW = LW + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_XFER,
    S_TRAIL,
    S_GAP
  } state_e;

  state_e          state_q, state_d;

  // Frame configuration. It is latched at the start of the frame, so later
  // changes on the live ports do not disturb a frame in flight.
  logic [LW-1:0]   len_q, len_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            cpha_q, cpha_d;

  // Datapath
  logic [DW-1:0]   tx_q, tx_d;          // word being sent
  logic [DW-1:0]   rx_q, rx_d;          // receive shift register
  logic [LW-1:0]   bit_q, bit_d;        // index of the bit currently on MOSI
  logic [DIVW-1:0] cnt_q, cnt_d;        // half-period divider
  logic [EW-1:0]   edge_q, edge_d;      // SCLK edges already produced

  // Registered outputs
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            csn_q, csn_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   data_rx_q, data_rx_d;
  logic            busy_q, busy_d;

  logic            start;
  logic            tick;
  logic            lead_edge;
  logic            last_edge;
  logic [LW-1:0]   bit_dn;
  logic [DW-1:0]   len_mask;

  assign start     = i_en & ~i_tx_empty & ~i_rx_full;
  // One half-period has elapsed when the divider reaches the latched CLKDIV.
  assign tick      = (cnt_q == div_q);
  // The next edge is number edge_q+1. It is odd (leading) when edge_q is even.
  assign lead_edge = ~edge_q[0];
  // The next edge is edge 2N when edge_q == 2N-1 == {len, 1}.
  assign last_edge = (edge_q == {1'b0, len_q, 1'b1});
  assign bit_dn    = bit_q - 1'b1;

  // Low N bits set. This mask keeps o_dataRX zero-extended.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < DW; i++) begin
      len_mask[i] = (i <= int'(len_q));
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d takes its hold value before the case statement, so no
    // path through the case can leave a signal unassigned and infer a latch.
    state_d   = state_q;
    len_d     = len_q;
    div_d     = div_q;
    cpha_d    = cpha_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_d     = bit_q;
    edge_d    = edge_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    csn_d     = csn_q;
    data_rx_d = data_rx_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        sclk_d = CPolPha[1];
        cnt_d  = '0;
        edge_d = '0;
        if (start) begin
          rd_d    = 1'b1;
          tx_d    = i_dataTX;
          len_d   = LEN;
          div_d   = CLKDIV;
          cpha_d  = CPolPha[0];
          bit_d   = LEN;
          rx_d    = '0;
          // The MSB is on MOSI for the whole LEAD phase in both CPHA modes.
          mosi_d  = i_dataTX[LEN];
          csn_d   = 1'b0;
          state_d = S_LEAD;
        end
      end

      S_LEAD: begin
        if (tick) state_d = S_XFER;
      end

      S_XFER: begin
        if (tick) begin
          edge_d = edge_q + 1'b1;
          sclk_d = ~sclk_q;
          // CPHA=0 samples on leading edges and CPHA=1 on trailing edges.
          if (lead_edge ^ cpha_q) rx_d = {rx_q[DW-2:0], i_MISO};
          if (cpha_q) begin
            // Drive the current bit on each leading edge, then step down.
            // The index stops at 0 so that it never wraps.
            if (lead_edge) begin
              mosi_d = tx_q[bit_q];
              if (bit_q != '0) bit_d = bit_dn;
            end
          end else if (!lead_edge && !last_edge) begin
            // The MSB is already on the line, so only trailing edges
            // 2..2N-2 advance to the next bit.
            bit_d  = bit_dn;
            mosi_d = tx_q[bit_dn];
          end
          if (last_edge) state_d = S_TRAIL;
        end
      end

      S_TRAIL: begin
        if (tick) begin
          csn_d     = 1'b1;
          wr_d      = 1'b1;
          data_rx_d = rx_q & len_mask;
          state_d   = S_GAP;
        end
      end

      S_GAP: begin
        if (tick) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset as well as the control registers.
  // A frame that rstn aborts then leaves no stale word, bit index or count
  // behind for the next frame.
  always_ff @(posedge sclk_sample or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      div_q     <= '0;
      cpha_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      edge_q    <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      csn_q     <= 1'b1;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      data_rx_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only. Every register samples the
      // pre-edge value of the others, whatever order the lines are in.
      state_q   <= state_d;
      len_q     <= len_d;
      div_q     <= div_d;
      cpha_q    <= cpha_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      csn_q     <= csn_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      data_rx_q <= data_rx_d;
      busy_q    <= busy_d;
    end
  end

  assign o_rd_TX  = rd_q;
  assign o_wr_RX  = wr_q;
  assign o_dataRX = data_rx_q;
  assign o_busy   = busy_q;
  assign o_SCLK   = sclk_q;
  assign o_MOSI   = mosi_q;
  assign o_CSn    = csn_q;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Scoreboard bench for spi_master. Each queued TX word pushes the response
//   the bench expects into exp_q: the RX word, the MOSI bits the slave sees,
//   the CSn low time, the SCLK edge count, the half-period and the idle level.
//   A monitor process pops exp_q whenever o_wr_RX pulses and compares.
//   The bench also holds a TX FIFO model and an SPI slave model.
// -----------------------------------------------------------------------------
module tb_spi_master;

  localparam int DW   = 16;
  localparam int DIVW = 8;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            en = 1'b0;
  logic            tx_empty = 1'b1;
  logic            rd_tx;
  logic [DW-1:0]   data_tx = '0;
  logic            rx_full = 1'b0;
  logic            wr_rx;
  logic [DW-1:0]   data_rx;
  logic [1:0]      cpolpha = 2'b00;
  logic [3:0]      len = 4'd7;
  logic [DIVW-1:0] clkdiv = '0;
  logic            busy, sclk, mosi, miso, csn;

  always #5 clk = ~clk;

  spi_master #(.DW(DW), .DIVW(DIVW)) dut (
    .sclk_sample (clk),
    .rstn        (rstn),
    .i_en        (en),
    .i_tx_empty  (tx_empty),
    .o_rd_TX     (rd_tx),
    .i_dataTX    (data_tx),
    .i_rx_full   (rx_full),
    .o_wr_RX     (wr_rx),
    .o_dataRX    (data_rx),
    .CPolPha     (cpolpha),
    .LEN         (len),
    .CLKDIV      (clkdiv),
    .o_busy      (busy),
    .o_SCLK      (sclk),
    .o_MOSI      (mosi),
    .i_MISO      (miso),
    .o_CSn       (csn)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Expected frame records
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [15:0] rx;     // expected o_dataRX
    logic [15:0] mosi;   // bits the slave should see, MSB first
    int          low;    // CSn low cycles
    int          edges;  // SCLK edges
    int          half;   // SCLK half-period
    logic        cpol;
    logic        cpha;
    logic [3:0]  len;
    logic [15:0] sword;  // word the slave model returns
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] tx_fifo[$];

  // MISO source: 0 = loopback of MOSI, 1 = slave model, 2 = constant 1
  int   miso_mode = 0;
  logic slave_miso = 1'b0;
  assign miso = (miso_mode == 0) ? mosi : ((miso_mode == 1) ? slave_miso : 1'b1);

  // Queue a TX word. The expected values come from the current LEN, CLKDIV
  // and CPolPha settings.
  task automatic queue_word(input string name, input logic [15:0] tx, input logic [15:0] rx,
                            input logic [15:0] sword, input bit expect_push);
    exp_t e;
    int n = int'(len) + 1;
    int d = int'(clkdiv) + 1;
    logic [15:0] m = 16'hFFFF >> (16 - n);
    e.name  = name;
    e.rx    = rx;
    e.mosi  = tx & m;
    e.low   = d * (2 * n + 2);
    e.edges = 2 * n;
    e.half  = d;
    e.cpol  = cpolpha[1];
    e.cpha  = cpolpha[0];
    e.len   = len;
    e.sword = sword;
    tx_fifo.push_back(tx);
    if (expect_push) exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // TX FIFO model (show-ahead). It pops on o_rd_TX.
  // ---------------------------------------------------------------------------
  int n_pops = 0;
  int pop_empty = 0;
  always @(negedge clk) begin
    if (rd_tx) begin
      if (tx_fifo.size() == 0) pop_empty++;
      else begin
        void'(tx_fifo.pop_front());
        n_pops++;
      end
    end
    #1;
    tx_empty = (tx_fifo.size() == 0);
    data_tx  = tx_empty ? '0 : tx_fifo[0];
  end

  // ---------------------------------------------------------------------------
  // Monitor, slave model and scoreboard
  // ---------------------------------------------------------------------------
  int          low_cnt = 0, edges = 0, since = 0, hmin = 0, hmax = 0, sbit = 0;
  int          cyc = 0, last_fall = -1, last_period = 0;
  logic [15:0] mosi_seen = '0;
  logic        sclk_start = 1'b0, csn_prev = 1'b1, sclk_prev = 1'b0;
  bit          odd_e;
  exp_t        cur, got_e;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      csn_prev  = 1'b1;
      sclk_prev = sclk;
    end else begin
      if (!csn) begin
        if (csn_prev) begin
          if (last_fall >= 0) last_period = cyc - last_fall;
          last_fall  = cyc;
          low_cnt    = 0;
          edges      = 0;
          since      = 0;
          hmin       = 1 << 30;
          hmax       = 0;
          mosi_seen  = '0;
          sclk_start = sclk;
          if (exp_q.size() > 0) cur = exp_q[0];
          sbit = int'(cur.len);
          if (!cur.cpha) slave_miso = cur.sword[sbit];
        end
        low_cnt++;
        since++;
        if (sclk != sclk_prev) begin
          if (edges > 0) begin
            if (since < hmin) hmin = since;
            if (since > hmax) hmax = since;
          end
          edges++;
          since = 0;
          odd_e = (edges % 2 == 1);
          // The slave samples MOSI on leading edges for CPHA=0 and on
          // trailing edges for CPHA=1.
          if (odd_e ^ cur.cpha) mosi_seen = {mosi_seen[14:0], mosi};
          if (cur.cpha) begin
            if (odd_e) begin
              slave_miso = cur.sword[sbit];
              if (sbit > 0) sbit--;
            end
          end else if (!odd_e && sbit > 0) begin
            sbit--;
            slave_miso = cur.sword[sbit];
          end
        end
      end
      if (wr_rx) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_push: got o_dataRX=%0h, expected no push", data_rx);
        end else begin
          got_e = exp_q.pop_front();
          check({got_e.name, "_rx"},      data_rx,    got_e.rx);
          check({got_e.name, "_mosi"},    mosi_seen,  got_e.mosi);
          check({got_e.name, "_csn_low"}, low_cnt,    got_e.low);
          check({got_e.name, "_edges"},   edges,      got_e.edges);
          check({got_e.name, "_hmin"},    hmin,       got_e.half);
          check({got_e.name, "_hmax"},    hmax,       got_e.half);
          check({got_e.name, "_idle"},    sclk_start, got_e.cpol);
        end
      end
      csn_prev  = csn;
      sclk_prev = sclk;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  bit ok;
  int bad;

  task automatic wait_done(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #2;
      done = (exp_q.size() == 0) && (tx_fifo.size() == 0) && !busy;
    end
    check({name, "_done"}, done, 1);
  endtask

  task automatic wait_csn_low(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = !csn;
    end
    check({name, "_csn_fell"}, seen, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int pops0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_csn",  csn, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_rd",   rd_tx, 0);
    check("rst_wr",   wr_rx, 0);
    check("rst_data", data_rx, 0);
    check("rst_busy", busy, 0);
    rstn = 1'b1;
    @(negedge clk);
    en = 1'b1;

    // 1. Mode 0, 8 bits, D=1, loopback. Two words, so the period is measurable.
    miso_mode = 0; cpolpha = 2'b00; len = 4'd7; clkdiv = 8'd0;
    @(negedge clk);
    queue_word("t1a", 16'h00A5, 16'h00A5, 16'h0000, 1);
    queue_word("t1b", 16'h005A, 16'h005A, 16'h0000, 1);
    wait_done("t1", 200);
    check("t1_period", last_period, 20);

    // 2. All four modes, 16 bits, D=4. The slave model returns 0xBEEF.
    miso_mode = 1; len = 4'd15; clkdiv = 8'd3;
    for (int m = 0; m < 4; m++) begin
      cpolpha = 2'(m);
      repeat (3) @(negedge clk);
      check($sformatf("t2_idle_sclk_m%0d", m), sclk, cpolpha[1]);
      queue_word($sformatf("t2_m%0d", m), 16'h1234, 16'hBEEF, 16'hBEEF, 1);
      wait_done($sformatf("t2_m%0d", m), 400);
    end

    // 3. Three back-to-back words, D=2, N=8. The period is 1+2*19 = 39.
    miso_mode = 0; cpolpha = 2'b00; len = 4'd7; clkdiv = 8'd1;
    @(negedge clk);
    pops0 = n_pops;
    queue_word("t3a", 16'h0011, 16'h0011, 16'h0000, 1);
    queue_word("t3b", 16'h0022, 16'h0022, 16'h0000, 1);
    queue_word("t3c", 16'h0033, 16'h0033, 16'h0000, 1);
    wait_done("t3", 400);
    check("t3_pops", n_pops - pops0, 3);
    check("t3_period", last_period, 39);

    // 4. RX FIFO full blocks the start of a frame.
    clkdiv = 8'd0;
    @(negedge clk);
    rx_full = 1'b1;
    pops0 = n_pops;
    queue_word("t4", 16'h00C6, 16'h00C6, 16'h0000, 1);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (!csn || rd_tx || busy) bad++;
    end
    check("t4_held_idle", bad, 0);
    check("t4_no_pop", n_pops - pops0, 0);
    rx_full = 1'b0;
    @(negedge clk);
    check("t4_rd_next_cycle", rd_tx, 1);
    check("t4_csn_next_cycle", csn, 0);
    wait_done("t4", 200);

    // 5. Reset at SCLK edge 5. The aborted word is not pushed and the next
    //    word runs normally.
    clkdiv = 8'd1;
    @(negedge clk);
    queue_word("t5a", 16'h003C, 16'h003C, 16'h0000, 0);
    queue_word("t5b", 16'h00C3, 16'h00C3, 16'h0000, 1);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      #2;
      ok = !csn && (edges >= 5);
    end
    check("t5_reached_edge5", ok, 1);
    rstn = 1'b0;
    #1;
    check("t5_csn", csn, 1);
    check("t5_sclk", sclk, 0);
    check("t5_wr", wr_rx, 0);
    check("t5_busy", busy, 0);
    check("t5_data", data_rx, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wait_done("t5", 200);

    // 6. LEN=0, MISO=1. A LEN change in mid-frame takes effect on the next frame.
    miso_mode = 2; cpolpha = 2'b00; len = 4'd0; clkdiv = 8'd0;
    @(negedge clk);
    queue_word("t6a", 16'h0000, 16'h0001, 16'h0000, 1);
    wait_csn_low("t6");
    @(posedge clk);
    #1;
    len = 4'd3;
    queue_word("t6b", 16'h000A, 16'h000F, 16'h0000, 1);
    wait_done("t6", 200);

    // 7. i_en falls mid-frame. The frame finishes and the next word waits.
    miso_mode = 0; len = 4'd7;
    @(negedge clk);
    queue_word("t7a", 16'h0081, 16'h0081, 16'h0000, 1);
    queue_word("t7b", 16'h007E, 16'h007E, 16'h0000, 1);
    wait_csn_low("t7");
    en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #2;
      ok = (exp_q.size() == 1) && !busy;
    end
    check("t7_first_done", ok, 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (!csn || busy) bad++;
    end
    check("t7_no_new_frame", bad, 0);
    check("t7_word_kept", tx_fifo.size(), 1);
    en = 1'b1;
    wait_done("t7", 200);

    check("never_pop_empty", pop_empty, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
